// File: rtl/simplearm_mem_pkg.sv
// Shared types and helpers for the SimpleARM unified memory path.
package simplearm_mem_pkg;

  localparam int WORD_W = 32;

  // Kind of access granted in the current cycle
  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_IFETCH,
    ACC_LOAD,
    ACC_STORE
  } acc_kind_t;

  // Word accesses only: the low two byte-address bits must be zero
  function automatic logic is_aligned(input logic [WORD_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive cycles a pending fetch has been denied.
module starve_counter #(
  parameter int CNT_W    = 4,
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic ge_max
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Next count: clear wins over increment; hold at all-ones instead of wrapping
  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign ge_max = (cnt_reg >= CNT_W'(MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between instruction fetch and data
// load/store. Data has priority; a starvation counter forces a fetch grant.
// Responses come back exactly one cycle after the grant.
module mem_port_arbiter
  import simplearm_mem_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [WORD_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [WORD_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_err,
  output logic [WORD_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  logic              ge_max;
  logic              force_i;
  logic              i_aligned;
  logic              d_aligned;
  acc_kind_t         acc_kind;

  logic              i_rvalid_reg;
  logic [WORD_W-1:0] i_rdata_reg;
  logic              i_err_reg;
  logic              d_rvalid_reg;
  logic [WORD_W-1:0] d_rdata_reg;
  logic              d_err_reg;

  assign i_aligned = is_aligned(i_addr);
  assign d_aligned = is_aligned(d_addr);
  assign force_i   = i_req && ge_max;

  // Grant selection; nothing is granted while reset is held so no write can slip through
  always_comb begin
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    acc_kind = ACC_NONE;
    if (!reset) begin
      if (force_i) begin
        i_gnt    = 1'b1;
        acc_kind = ACC_IFETCH;
      end else if (d_req) begin
        d_gnt    = 1'b1;
        acc_kind = d_we ? ACC_STORE : ACC_LOAD;
      end else if (i_req) begin
        i_gnt    = 1'b1;
        acc_kind = ACC_IFETCH;
      end
    end
  end

  // Memory side: address follows the winner (fetch address when idle)
  assign mem_addr  = d_gnt ? d_addr : i_addr;
  assign mem_wdata = d_wdata;
  assign mem_we    = (acc_kind == ACC_STORE) && d_aligned;

  starve_counter #(
    .CNT_W    (CNT_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .inc    (i_req && !i_gnt),
    .clr    (i_gnt || !i_req),
    .ge_max (ge_max)
  );

  // Fetch response register: data or error captured in the grant cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      i_rvalid_reg <= 1'b0;
      i_rdata_reg  <= '0;
      i_err_reg    <= 1'b0;
    end else begin
      i_rvalid_reg <= i_gnt;
      if (i_gnt) begin
        i_rdata_reg <= i_aligned ? mem_rdata : '0;
        i_err_reg   <= !i_aligned;
      end
    end
  end

  // Data response register: loads return memory, stores return zero as an ack
  always_ff @(posedge clk) begin
    if (reset) begin
      d_rvalid_reg <= 1'b0;
      d_rdata_reg  <= '0;
      d_err_reg    <= 1'b0;
    end else begin
      d_rvalid_reg <= d_gnt;
      if (d_gnt) begin
        d_rdata_reg <= ((acc_kind == ACC_LOAD) && d_aligned) ? mem_rdata : '0;
        d_err_reg   <= !d_aligned;
      end
    end
  end

  assign i_rvalid = i_rvalid_reg;
  assign i_rdata  = i_rdata_reg;
  assign i_err    = i_err_reg;
  assign d_rvalid = d_rvalid_reg;
  assign d_rdata  = d_rdata_reg;
  assign d_err    = d_err_reg;

endmodule
